// File: rtl/qpu_exu_wbck_arb.sv
// Write-back arbiter: merges ALU and long-pipe results onto classical/quantum regfile write ports.
// Optional starvation guard enabled by defining QPU_WBCK_STARVE_GUARD_EN.
module qpu_exu_wbck_arb #(
    parameter int XLEN             = 32,
    parameter int RFIDX_REAL_WIDTH = 6,
    parameter int STARVE_MAX       = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        alu_wbck_i_valid,
    output logic                        alu_wbck_i_ready,
    input  logic [RFIDX_REAL_WIDTH-1:0] alu_wbck_i_idx,
    input  logic [XLEN-1:0]             alu_wbck_i_data,
    input  logic                        lng_wbck_i_valid,
    output logic                        lng_wbck_i_ready,
    input  logic [RFIDX_REAL_WIDTH-1:0] lng_wbck_i_idx,
    input  logic [XLEN-1:0]             lng_wbck_i_data,
    output logic                        cwbck_dest_wen,
    output logic [RFIDX_REAL_WIDTH-1:0] cwbck_dest_idx,
    output logic [XLEN-1:0]             cwbck_dest_data,
    output logic                        qcwbck_dest_wen,
    output logic [RFIDX_REAL_WIDTH-1:0] qcwbck_dest_idx,
    output logic [XLEN-1:0]             qcwbck_dest_data,
    output logic [1:0]                  arb_starve_cnt
);
    localparam int MSB = RFIDX_REAL_WIDTH - 1;

    logic alu_q_sel, lng_q_sel, same_file, starve_hit;
    logic alu_acc, lng_acc;

    assign alu_q_sel = alu_wbck_i_idx[MSB];
    assign lng_q_sel = lng_wbck_i_idx[MSB];
    assign same_file = alu_wbck_i_valid & lng_wbck_i_valid & (alu_q_sel == lng_q_sel);

    // Only a same-file collision needs arbitration; otherwise both sides may go.
    assign alu_wbck_i_ready = rst_n & (~same_file | starve_hit);
    assign lng_wbck_i_ready = rst_n & (~same_file | ~starve_hit);
    assign alu_acc = alu_wbck_i_valid & alu_wbck_i_ready;
    assign lng_acc = lng_wbck_i_valid & lng_wbck_i_ready;

`ifdef QPU_WBCK_STARVE_GUARD_EN
    logic [1:0] starve_cnt_q, starve_cnt_d;

    assign starve_hit = (starve_cnt_q == 2'(STARVE_MAX));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (alu_acc)
            starve_cnt_d = 2'd0;
        else if (alu_wbck_i_valid && !starve_hit)
            starve_cnt_d = starve_cnt_q + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_cnt_q <= 2'd0;
        else        starve_cnt_q <= starve_cnt_d;
    end

    assign arb_starve_cnt = starve_cnt_q;
`else
    assign starve_hit     = 1'b0;
    assign arb_starve_cnt = 2'd0;
`endif

    // Per-file source select; the grant logic guarantees at most one source per file.
    logic                        c_sel_alu, c_any, c_wr, q_sel_alu, q_any;
    logic [RFIDX_REAL_WIDTH-1:0] c_src_idx, q_src_idx;
    logic [XLEN-1:0]             c_src_data, q_src_data;

    assign c_sel_alu  = alu_acc & ~alu_q_sel;
    assign c_any      = c_sel_alu | (lng_acc & ~lng_q_sel);
    assign c_src_idx  = c_sel_alu ? alu_wbck_i_idx  : lng_wbck_i_idx;
    assign c_src_data = c_sel_alu ? alu_wbck_i_data : lng_wbck_i_data;
    assign c_wr       = c_any & (|c_src_idx[MSB-1:0]);

    assign q_sel_alu  = alu_acc & alu_q_sel;
    assign q_any      = q_sel_alu | (lng_acc & lng_q_sel);
    assign q_src_idx  = q_sel_alu ? alu_wbck_i_idx  : lng_wbck_i_idx;
    assign q_src_data = q_sel_alu ? alu_wbck_i_data : lng_wbck_i_data;

    logic                        c_wen_q, q_wen_q;
    logic [RFIDX_REAL_WIDTH-1:0] c_idx_q, q_idx_q;
    logic [XLEN-1:0]             c_data_q, q_data_q;

    // Writes to classical x0 are accepted but dropped; idx/data keep the last real write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_wen_q  <= 1'b0;
            c_idx_q  <= '0;
            c_data_q <= '0;
            q_wen_q  <= 1'b0;
            q_idx_q  <= '0;
            q_data_q <= '0;
        end else begin
            c_wen_q <= c_wr;
            q_wen_q <= q_any;
            if (c_wr) begin
                c_idx_q  <= c_src_idx;
                c_data_q <= c_src_data;
            end
            if (q_any) begin
                q_idx_q  <= q_src_idx;
                q_data_q <= q_src_data;
            end
        end
    end

    assign cwbck_dest_wen   = c_wen_q;
    assign cwbck_dest_idx   = c_idx_q;
    assign cwbck_dest_data  = c_data_q;
    assign qcwbck_dest_wen  = q_wen_q;
    assign qcwbck_dest_idx  = q_idx_q;
    assign qcwbck_dest_data = q_data_q;
endmodule

// File: tb/tb_qpu_exu_wbck_arb.sv
// Scoreboard bench for qpu_exu_wbck_arb; expectations follow QPU_WBCK_STARVE_GUARD_EN if defined.
module tb_qpu_exu_wbck_arb;
    localparam int STARVE_MAX = 3;
`ifdef QPU_WBCK_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_wbck_i_valid = 1'b0, lng_wbck_i_valid = 1'b0;
    logic        alu_wbck_i_ready, lng_wbck_i_ready;
    logic [5:0]  alu_wbck_i_idx = '0, lng_wbck_i_idx = '0;
    logic [31:0] alu_wbck_i_data = '0, lng_wbck_i_data = '0;
    logic        cwbck_dest_wen, qcwbck_dest_wen;
    logic [5:0]  cwbck_dest_idx, qcwbck_dest_idx;
    logic [31:0] cwbck_dest_data, qcwbck_dest_data;
    logic [1:0]  arb_starve_cnt;

    qpu_exu_wbck_arb #(.XLEN(32), .RFIDX_REAL_WIDTH(6), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_wbck_i_valid(alu_wbck_i_valid), .alu_wbck_i_ready(alu_wbck_i_ready),
        .alu_wbck_i_idx(alu_wbck_i_idx), .alu_wbck_i_data(alu_wbck_i_data),
        .lng_wbck_i_valid(lng_wbck_i_valid), .lng_wbck_i_ready(lng_wbck_i_ready),
        .lng_wbck_i_idx(lng_wbck_i_idx), .lng_wbck_i_data(lng_wbck_i_data),
        .cwbck_dest_wen(cwbck_dest_wen), .cwbck_dest_idx(cwbck_dest_idx),
        .cwbck_dest_data(cwbck_dest_data),
        .qcwbck_dest_wen(qcwbck_dest_wen), .qcwbck_dest_idx(qcwbck_dest_idx),
        .qcwbck_dest_data(qcwbck_dest_data),
        .arb_starve_cnt(arb_starve_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wen;
        logic [5:0]  idx;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        wr_t        c;
        wr_t        q;
        logic [1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    wr_t  mc, mq;
    int   mcnt;
    int   errors = 0;
    int   checks = 0;

    // Reference model step: drives one cycle of stimulus, predicts readies and the next-cycle outputs.
    task automatic drive_cycle(input logic av, input logic [5:0] ai, input logic [31:0] ad,
                               input logic lv, input logic [5:0] li, input logic [31:0] ld,
                               output logic ear, output logic elr);
        logic same, hit, aa, la;
        exp_t e;
        @(negedge clk);
        alu_wbck_i_valid = av; alu_wbck_i_idx = ai; alu_wbck_i_data = ad;
        lng_wbck_i_valid = lv; lng_wbck_i_idx = li; lng_wbck_i_data = ld;
        #1;
        same = av && lv && (ai[5] == li[5]);
        hit  = GUARD && (mcnt == STARVE_MAX);
        ear  = !same || hit;
        elr  = !same || !hit;
        aa   = av && ear;
        la   = lv && elr;
        mc.wen = 1'b0;
        mq.wen = 1'b0;
        if (aa) begin
            if (ai[5]) mq = '{1'b1, ai, ad};
            else if (ai[4:0] != 5'd0) mc = '{1'b1, ai, ad};
        end
        if (la) begin
            if (li[5]) mq = '{1'b1, li, ld};
            else if (li[4:0] != 5'd0) mc = '{1'b1, li, ld};
        end
        if (GUARD) begin
            if (aa) mcnt = 0;
            else if (av && mcnt < STARVE_MAX) mcnt = mcnt + 1;
        end
        e.c = mc; e.q = mq; e.cnt = 2'(mcnt);
        exp_q.push_back(e);
    endtask

    // Scoreboard consumer: every queued expectation is compared one cycle after it was pushed.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({cwbck_dest_wen, cwbck_dest_idx, cwbck_dest_data} !== e.c) begin
                errors++;
                $display("FAIL cwbck: got wen=%0b idx=%h data=%h want wen=%0b idx=%h data=%h",
                         cwbck_dest_wen, cwbck_dest_idx, cwbck_dest_data, e.c.wen, e.c.idx, e.c.data);
            end
            checks++;
            if ({qcwbck_dest_wen, qcwbck_dest_idx, qcwbck_dest_data} !== e.q) begin
                errors++;
                $display("FAIL qcwbck: got wen=%0b idx=%h data=%h want wen=%0b idx=%h data=%h",
                         qcwbck_dest_wen, qcwbck_dest_idx, qcwbck_dest_data, e.q.wen, e.q.idx, e.q.data);
            end
            checks++;
            if (arb_starve_cnt !== e.cnt) begin
                errors++;
                $display("FAIL starve_cnt: got %0d want %0d", arb_starve_cnt, e.cnt);
            end
        end
    end

    task automatic test_reset();
        alu_wbck_i_valid = 1'b1; lng_wbck_i_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({alu_wbck_i_ready, lng_wbck_i_ready, cwbck_dest_wen, qcwbck_dest_wen, arb_starve_cnt} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ar=%0b lr=%0b cw=%0b qw=%0b cnt=%0d want all 0",
                     alu_wbck_i_ready, lng_wbck_i_ready, cwbck_dest_wen, qcwbck_dest_wen, arb_starve_cnt);
        end
        checks++;
        if ({cwbck_dest_idx, cwbck_dest_data, qcwbck_dest_idx, qcwbck_dest_data} !== 76'b0) begin
            errors++;
            $display("FAIL reset_data: got cidx=%h cdata=%h qidx=%h qdata=%h want 0",
                     cwbck_dest_idx, cwbck_dest_data, qcwbck_dest_idx, qcwbck_dest_data);
        end
        alu_wbck_i_valid = 1'b0; lng_wbck_i_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_alu_single();
        logic ear, elr;
        drive_cycle(1'b1, 6'h05, 32'h1234, 1'b0, 6'h00, 32'h0, ear, elr);
        checks++;
        if (alu_wbck_i_ready !== 1'b1) begin
            errors++;
            $display("FAIL alu_single_ready: got %0b want 1", alu_wbck_i_ready);
        end
        drive_cycle(1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 32'h0, ear, elr);
    endtask

    task automatic test_dual_file();
        logic ear, elr;
        drive_cycle(1'b1, 6'h03, 32'hAAAA_0003, 1'b1, 6'h23, 32'hBBBB_0023, ear, elr);
        checks++;
        if ({alu_wbck_i_ready, lng_wbck_i_ready} !== 2'b11) begin
            errors++;
            $display("FAIL dual_ready: got ar=%0b lr=%0b want 1 1", alu_wbck_i_ready, lng_wbck_i_ready);
        end
        drive_cycle(1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 32'h0, ear, elr);
    endtask

    task automatic test_x0();
        logic ear, elr;
        drive_cycle(1'b1, 6'h00, 32'hFFFF, 1'b0, 6'h00, 32'h0, ear, elr);
        checks++;
        if (alu_wbck_i_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: got %0b want 1", alu_wbck_i_ready);
        end
        drive_cycle(1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 32'h0, ear, elr);
    endtask

    task automatic test_contention();
        logic ear, elr, want_alu;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 6'h01, 32'hA1A1, 1'b1, 6'h02, 32'hB2B2, ear, elr);
            want_alu = GUARD && (i == 3);
            checks++;
            if ({alu_wbck_i_ready, lng_wbck_i_ready} !== {want_alu, !want_alu}) begin
                errors++;
                $display("FAIL contention_c%0d: got ar=%0b lr=%0b want ar=%0b lr=%0b",
                         i, alu_wbck_i_ready, lng_wbck_i_ready, want_alu, !want_alu);
            end
        end
        drive_cycle(1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 32'h0, ear, elr);
    endtask

    task automatic test_back_to_back();
        logic ear, elr, av, lv;
        logic [5:0] ai, li;
        for (int i = 0; i < 40; i++) begin
            av = 1'($urandom_range(0, 1));
            lv = 1'($urandom_range(0, 1));
            ai = 6'($urandom_range(0, 63));
            li = 6'($urandom_range(0, 63));
            drive_cycle(av, ai, $urandom, lv, li, $urandom, ear, elr);
            checks++;
            if ({alu_wbck_i_ready, lng_wbck_i_ready} !== {ear, elr}) begin
                errors++;
                $display("FAIL b2b_ready_%0d: got ar=%0b lr=%0b want ar=%0b lr=%0b",
                         i, alu_wbck_i_ready, lng_wbck_i_ready, ear, elr);
            end
        end
        drive_cycle(1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 32'h0, ear, elr);
    endtask

    task automatic test_reset_mid();
        logic ear, elr;
        drive_cycle(1'b1, 6'h07, 32'h7777, 1'b1, 6'h27, 32'h2727, ear, elr);
        @(negedge clk);
        alu_wbck_i_valid = 1'b1; alu_wbck_i_idx = 6'h08; alu_wbck_i_data = 32'h8888;
        lng_wbck_i_valid = 1'b1; lng_wbck_i_idx = 6'h28; lng_wbck_i_data = 32'h2828;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({cwbck_dest_wen, qcwbck_dest_wen, arb_starve_cnt, alu_wbck_i_ready, lng_wbck_i_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid: got cw=%0b qw=%0b cnt=%0d ar=%0b lr=%0b want all 0",
                     cwbck_dest_wen, qcwbck_dest_wen, arb_starve_cnt, alu_wbck_i_ready, lng_wbck_i_ready);
        end
        alu_wbck_i_valid = 1'b0; lng_wbck_i_valid = 1'b0;
        mc = '0; mq = '0; mcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) drive_cycle(1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 32'h0, ear, elr);
    endtask

    initial begin
        mc = '0; mq = '0; mcnt = 0;
        test_reset();
        test_alu_single();
        test_dual_file();
        test_x0();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/qpu_exu_wbck_arb.md
QPU_EXU_WBCK_ARB -- requirements
Module: qpu_exu_wbck_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter RFIDX_REAL_WIDTH, default 6, register index width; MSB=1 selects quantum file, MSB=0 selects classical file.
REQ-003 SHALL have parameter STARVE_MAX, default 3, maximum consecutive ALU losses before forced ALU grant.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports alu_wbck_i_valid input 1 / alu_wbck_i_ready output 1  ALU write-back handshake.
REQ-007 SHALL have ports alu_wbck_i_idx input RFIDX_REAL_WIDTH / alu_wbck_i_data input XLEN  ALU destination and data.
REQ-008 SHALL have ports lng_wbck_i_valid input 1 / lng_wbck_i_ready output 1  long-pipe (FMR/measure) write-back handshake.
REQ-009 SHALL have ports lng_wbck_i_idx input RFIDX_REAL_WIDTH / lng_wbck_i_data input XLEN  long-pipe destination and data.
REQ-010 SHALL have ports cwbck_dest_wen output 1, cwbck_dest_idx output RFIDX_REAL_WIDTH, cwbck_dest_data output XLEN  classical regfile write port.
REQ-011 SHALL have ports qcwbck_dest_wen output 1, qcwbck_dest_idx output RFIDX_REAL_WIDTH, qcwbck_dest_data output XLEN  quantum regfile write port.
REQ-012 SHALL have port arb_starve_cnt output 2  current ALU starvation count (status).

Function
REQ-013 SHALL accept a request when valid & ready in the same cycle; ready SHALL be combinational from valids, idx MSBs and starvation state only.
REQ-014 SHALL drive all write-port outputs from registers; write occurs exactly 1 cycle after acceptance.
REQ-015 SHALL route an accepted request to the quantum port if idx MSB=1, else to the classical port.
REQ-016 SHALL grant both requesters in the same cycle when both valid and their idx MSBs differ.
REQ-017 SHALL, when both valid and targeting the same file, grant long-pipe unless arb_starve_cnt==STARVE_MAX, in which case grant ALU.
REQ-018 SHALL grant a lone valid requester unconditionally.
REQ-019 SHALL increment arb_starve_cnt when ALU valid and not accepted, saturating at STARVE_MAX; SHALL clear it on ALU acceptance; SHALL hold otherwise.
REQ-020 SHALL suppress wen (drop write, still accept) for classical idx with lower RFIDX_REAL_WIDTH-1 bits ==0 (x0).
REQ-021 SHALL deassert each wen the cycle after no request was accepted to that file; idx/data SHALL hold last value when wen=0.
REQ-022 SHALL never assert both requesters' writes to the same file in one cycle.

Reset
REQ-023 SHALL, on rst_n low, asynchronously clear cwbck_dest_wen, qcwbck_dest_wen, arb_starve_cnt, all idx/data registers to 0.
REQ-024 SHALL drive both ready outputs 0 while rst_n low; a request in flight at reset assertion SHALL be discarded.

Configuration
REQ-025 SHALL use macro QPU_WBCK_STARVE_GUARD_EN: defined -> REQ-017/019 starvation guard active; undefined -> strict long-pipe priority, arb_starve_cnt tied to 0, no counter flops.

Verification
REQ-026 ALU valid idx=6'h05 data=0x1234 alone -> ready=1; next cycle cwbck_dest_wen=1 idx=5 data=0x1234.
REQ-027 ALU idx=6'h03, long idx=6'h23 same cycle -> both ready; next cycle cwbck(3) and qcwbck(0x23) written together.
REQ-028 ALU and long both classical held valid 5 cycles, guard enabled, STARVE_MAX=3 -> long granted cycles 0-2, ALU granted cycle 3, counter back to 0.
REQ-029 Same as REQ-028 with QPU_WBCK_STARVE_GUARD_EN undefined -> ALU never granted while long valid; arb_starve_cnt stays 0.
REQ-030 ALU valid idx=6'h00 data=0xFFFF -> accepted, cwbck_dest_wen stays 0.
REQ-031 rst_n pulsed low mid-acceptance -> all wen, counter 0 immediately; no write after release.
